// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
// Groups the request/result signals of the bit-serial subtractor.
//   start      : request, sampled only while the subtractor is not busy
//   minuend    : operand A, captured on an accepted start
//   subtrahend : operand B, captured on an accepted start
//   busy       : operation in progress
//   done       : one-cycle pulse when diff/neg become valid
//   diff       : magnitude |A-B|
//   neg        : 1 when A < B
// master drives the request side, slave (the subtractor) drives the results.
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int WIDTH = 4
) ();
  logic             start;
  logic [WIDTH-1:0] minuend;
  logic [WIDTH-1:0] subtrahend;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             neg;

  modport master (
    output start, minuend, subtrahend,
    input  busy, done, diff, neg
  );

  modport slave (
    input  start, minuend, subtrahend,
    output busy, done, diff, neg
  );
endinterface

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor: A - B computed LSB first through one
// full-subtractor cell with a registered borrow, then converted to
// sign-magnitude for the display path.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_subtractor_if.slave (start/operands in, busy/done/diff/neg out)
// Timing: start accepted at edge T, WIDTH SUB cycles, one FIX cycle, done high
// in the cycle after edge T+WIDTH+1. Every output comes straight from a flop
// or from a decode of the state register.
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_part;
  logic             r_bor;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_neg;

  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_bor_next;

  // Final borrow set means the raw difference wrapped: recover |A-B| by
  // two's complement. A zero partial never carries a borrow, so a zero
  // magnitude is never flagged negative.
  function automatic logic [WIDTH-1:0] f_magnitude(
    input logic [WIDTH-1:0] part,
    input logic             bor
  );
    if (bor) begin
      return (~part) + WIDTH'(1);
    end
    return part;
  endfunction

  // DONE accepts a new request exactly like IDLE, allowing back-to-back ops.
  assign w_accept   = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  // Full-subtractor cell on the current LSBs.
  assign w_d        = r_a[0] ^ r_b[0] ^ r_bor;
  assign w_bor_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_bor);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_state_next = S_SUB;
      S_SUB:  if (w_last)   w_state_next = S_FIX;
      S_FIX:  w_state_next = S_DONE;
      S_DONE: w_state_next = w_accept ? S_SUB : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Serial datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_part <= '0;
      r_bor  <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_neg  <= 1'b0;
    end else if (w_accept) begin
      r_a    <= bus.minuend;
      r_b    <= bus.subtrahend;
      r_part <= '0;
      r_bor  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        S_SUB: begin
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          // Result bits enter at the MSB so bit 0 lands at position 0
          // after WIDTH shifts.
          r_part <= {w_d, r_part[WIDTH-1:1]};
          r_bor  <= w_bor_next;
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        S_FIX: begin
          r_diff <= f_magnitude(r_part, r_bor);
          r_neg  <= r_bor;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state == S_SUB) || (r_state == S_FIX);
  assign bus.done = (r_state == S_DONE);
  assign bus.diff = r_diff;
  assign bus.neg  = r_neg;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit unsigned subtractor computing minuend - subtrahend one bit per clock, LSB first, through a single registered-borrow full-subtractor cell.
- Result is presented in sign-magnitude form (magnitude plus negative flag), ready for the board's seven-segment/LED display path.
- Complements the combinational ripple adder in the arithmetic set, trading area for latency, and adds a start/busy/done handshake.

Parameters:
- WIDTH, 4, operand and magnitude width in bits (legal range 2..16).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- minuend  input  WIDTH  operand A; captured on an accepted start.
- subtrahend  input  WIDTH  operand B; captured on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when diff/neg become valid.
- diff  output  WIDTH  magnitude |A-B|.
- neg  output  1  1 when A<B.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, diff=0, neg=0.
  - Operand shift registers, partial result, borrow register and bit counter all cleared.
- States: IDLE, SUB, FIX, DONE.
- IDLE: if start=1, capture A and B into shift registers, clear the borrow register and the counter, go to SUB. Otherwise stay in IDLE.
- SUB: lasts exactly WIDTH cycles.
  - Each cycle uses a=A[0], b=B[0], the registered borrow bor.
  - d = a^b^bor, shifted into the partial result from the MSB end.
  - bor_next = (~a&b) | (~(a^b)&bor).
  - A and B shift right by 1; counter increments.
  - After the WIDTH-th bit, go to FIX.
- FIX: one cycle.
  - Final borrow=1 means A<B: neg_next=1, magnitude = (~partial)+1, truncated to WIDTH bits.
  - Otherwise neg_next=0, magnitude = partial.
  - Go to DONE.
- DONE: one cycle.
  - diff and neg are registered with the FIX results in the transition into DONE; done=1 for this cycle only.
  - If start=1 in DONE, accept it exactly as IDLE does and go to SUB; otherwise go to IDLE.
- busy: 1 in SUB and FIX, 0 in IDLE and DONE.
- Latency: start accepted at edge T -> SUB over edges T+1..T+WIDTH -> FIX at edge T+WIDTH+1 -> done=1 in the cycle after edge T+WIDTH+1. For WIDTH=4, done is high 6 cycles after start is sampled.
- diff and neg hold their last value from one done until the next done. They do not change during SUB or FIX.
- start while busy=1 is ignored: no restart, no effect on the result.
- Operand inputs are don't-care except on the accepting edge.
- Equal operands: diff=0, neg=0. A result of 0 is never reported with neg=1.
- Full-scale negative (A=0, B=2^WIDTH-1): diff=2^WIDTH-1, neg=1. The magnitude always fits in WIDTH bits.
- rst_n asserted mid-operation aborts immediately to the reset state. No done is issued for the aborted operation.
- All outputs are registered. There is no combinational path from any input to any output.

Test Plan:
- Reset then start, A=9, B=3 (WIDTH=4) -> busy high 5 cycles; done pulses once 6 cycles after start; diff=6, neg=0.
- A=3, B=9 -> diff=6, neg=1; done is exactly one cycle wide; diff/neg stay stable afterwards with start=0.
- Boundary cases:
  - A=0, B=15 -> diff=15, neg=1.
  - A=15, B=0 -> diff=15, neg=0.
  - A=B=7 -> diff=0, neg=0.
- Start A=12, B=5; during busy assert start with A=1, B=14 -> second request ignored; diff=7, neg=0. Then start held high in the DONE cycle with A=2, B=4 -> back-to-back accept; next done gives diff=2, neg=1.
- Start A=10, B=2; pull rst_n low on the 3rd SUB cycle for 2 cycles -> outputs 0 immediately, no done. Then start A=4, B=4 -> diff=0, neg=0.
- Exhaustive sweep of all 256 (A,B) pairs at WIDTH=4, plus random pairs at WIDTH=8 -> diff=|A-B|, neg=(A<B) against a reference model, with the latency checked every time.
